// File: rtl/seq_tiled_mult_pkg.sv
// Shared types and derived-constant helpers for the sequential tiled multiplier.
// NT/K are functions because they depend on the instance's WIDTH and TILE.
package seq_tiled_mult_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_TILE  = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Number of tiles per operand.
  function automatic int calc_nt(input int width, input int tile);
    return width / tile;
  endfunction

  // Number of tile products needed for one full product.
  function automatic int calc_k(input int width, input int tile);
    return calc_nt(width, tile) * calc_nt(width, tile);
  endfunction

  // Bits needed to count 0..n-1, never less than one.
  function automatic int log2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/seq_tiled_mult_tile_mul.sv
// Combinational exact TILE x TILE unsigned multiplier; the single place to drop in
// an alternative or approximate tile multiplier.
module tile_mul
  import seq_tiled_mult_pkg::*;
#(
  parameter int TILE = DEF_TILE
) (
  input  logic [TILE-1:0]   A,
  input  logic [TILE-1:0]   B,
  output logic [2*TILE-1:0] P
);

  assign P = {{TILE{1'b0}}, A} * {{TILE{1'b0}}, B};

endmodule

// File: rtl/seq_tiled_mult.sv
// Iterative unsigned multiplier: one TILE x TILE partial product per clock on a shared
// tile multiplier, accumulated into a 2*WIDTH result, with valid/ready on both sides.
module seq_tiled_mult
  import seq_tiled_mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int TILE  = DEF_TILE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] P
);

  localparam int NT    = calc_nt(WIDTH, TILE);
  localparam int K     = calc_k(WIDTH, TILE);
  localparam int IDX_W = log2(K);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(K - 1);

  state_t             state;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] p_reg;
  logic [IDX_W-1:0]   idx;
  logic               out_valid_reg;

  int                 ti;
  int                 tj;
  logic [TILE-1:0]    a_tile;
  logic [TILE-1:0]    b_tile;
  logic [2*TILE-1:0]  tile_p;
  logic [2*WIDTH-1:0] tile_ext;
  logic [2*WIDTH-1:0] acc_next;

  // In DONE a new pair can be taken on the same edge the result leaves.
  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign out_valid = out_valid_reg;
  assign P         = p_reg;

  always_comb begin
    ti       = int'(idx) / NT;
    tj       = int'(idx) % NT;
    a_tile   = TILE'(a_reg >> (ti * TILE));
    b_tile   = TILE'(b_reg >> (tj * TILE));
    tile_ext = '0;
    tile_ext[2*TILE-1:0] = tile_p;
    acc_next = acc + (tile_ext << (TILE * (ti + tj)));
  end

  tile_mul #(
    .TILE(TILE)
  ) u_tile_mul (
    .A(a_tile),
    .B(b_tile),
    .P(tile_p)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      acc           <= '0;
      p_reg         <= '0;
      idx           <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= A;
            b_reg <= B;
            acc   <= '0;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= acc_next;
          idx <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            p_reg         <= acc_next;
            out_valid_reg <= 1'b1;
            idx           <= '0;
            state         <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            if (in_valid) begin
              a_reg <= A;
              b_reg <= B;
              acc   <= '0;
              idx   <= '0;
              state <= RUN;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_tiled_mult.sv
// Self-checking bench for seq_tiled_mult: three widths (4, 6, 8) side by side,
// directed vectors with literal results plus a cycle-level scoreboard model.
module tb_seq_tiled_mult;

  typedef struct {
    int prod;
    int ready;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid  [3];
  logic       out_ready [3];
  logic [7:0] a_in      [3];
  logic [7:0] b_in      [3];
  logic       in_ready  [3];
  logic       out_valid [3];
  logic [15:0] p_out    [3];

  logic        ir4, ir6, ir8, ov4, ov6, ov8;
  logic [7:0]  p4;
  logic [11:0] p6;
  logic [15:0] p8;

  int   widths [3] = '{4, 6, 8};
  exp_t sb [3][$];
  int   n_acc [3];
  int   n_res [3];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  bit   check_en = 1'b0;
  bit   sweep_on = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_tiled_mult #(.WIDTH(4), .TILE(2)) u_w4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(ir4),
    .A(a_in[0][3:0]), .B(b_in[0][3:0]), .out_valid(ov4), .out_ready(out_ready[0]), .P(p4));
  seq_tiled_mult #(.WIDTH(6), .TILE(2)) u_w6 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(ir6),
    .A(a_in[1][5:0]), .B(b_in[1][5:0]), .out_valid(ov6), .out_ready(out_ready[1]), .P(p6));
  seq_tiled_mult #(.WIDTH(8), .TILE(2)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(ir8),
    .A(a_in[2]), .B(b_in[2]), .out_valid(ov8), .out_ready(out_ready[2]), .P(p8));

  always_comb begin
    in_ready[0]  = ir4;
    in_ready[1]  = ir6;
    in_ready[2]  = ir8;
    out_valid[0] = ov4;
    out_valid[1] = ov6;
    out_valid[2] = ov8;
    p_out[0]     = {8'd0, p4};
    p_out[1]     = {4'd0, p6};
    p_out[2]     = p8;
  end

  function automatic int kval(input int k);
    return (widths[k] / 2) * (widths[k] / 2);
  endfunction

  function automatic int wmask(input int k);
    return (1 << widths[k]) - 1;
  endfunction

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s (W%0d) at cycle %0d: got %0d, expected %0d", name, widths[k], cyc, act, exp);
    end
  endtask

  // Scoreboard: a pair accepted on an edge yields A*B visible K cycles later,
  // held until the downstream takes it; nothing else may appear on the output.
  always @(negedge clk) begin
    if (check_en) begin
      for (int k = 0; k < 3; k++) begin
        bit   exp_ov;
        bit   exp_ir;
        exp_t e;
        exp_ov = (sb[k].size() > 0) && (cyc >= sb[k][0].ready);
        exp_ir = (sb[k].size() == 0) || (exp_ov && out_ready[k]);
        check("model out_valid", k, {31'd0, out_valid[k]}, {31'd0, exp_ov});
        check("model in_ready", k, {31'd0, in_ready[k]}, {31'd0, exp_ir});
        if (exp_ov) check("model P", k, {16'd0, p_out[k]}, sb[k][0].prod);
        if (rst_n && in_valid[k] && in_ready[k]) n_acc[k]++;
        if (rst_n && out_valid[k] && out_ready[k]) n_res[k]++;
        if (!rst_n) begin
          sb[k].delete();
        end else begin
          if (exp_ov && out_ready[k]) void'(sb[k].pop_front());
          if (in_valid[k] && exp_ir) begin
            e.prod  = (int'(a_in[k]) & wmask(k)) * (int'(b_in[k]) & wmask(k));
            e.ready = cyc + 1 + kval(k);
            sb[k].push_back(e);
          end
        end
      end
    end
  end

  task automatic applyStimulus(input int k, input logic [7:0] a, input logic [7:0] b, output int acc_c);
    int n;
    @(posedge clk);
    #1;
    in_valid[k] = 1'b1;
    a_in[k] = a;
    b_in[k] = b;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (in_ready[k] !== 1'b1 && n < 200);
    if (in_ready[k] !== 1'b1) begin
      check("in_ready within budget", k, {31'd0, in_ready[k]}, 1);
      in_valid[k] = 1'b0;
      acc_c = cyc;
    end else begin
      @(posedge clk);
      #1;
      acc_c = cyc;
      in_valid[k] = 1'b0;
    end
  endtask

  task automatic checkOutput(input int k, input int exp_p, input int exp_lat, input int acc_c);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (out_valid[k] !== 1'b1 && n < 200);
    if (out_valid[k] !== 1'b1) begin
      check("out_valid within budget", k, {31'd0, out_valid[k]}, 1);
    end else begin
      check("literal P", k, {16'd0, p_out[k]}, exp_p);
      check("latency", k, cyc - acc_c, exp_lat);
    end
  endtask

  task automatic sweep(input int k, input int count);
    int c;
    for (int n = 0; n < count; n++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      applyStimulus(k, 8'($urandom() & wmask(k)), 8'($urandom() & wmask(k)), c);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (sweep_on)
      for (int k = 0; k < 3; k++) out_ready[k] = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c, c1, c2, w;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0;
      out_ready[k] = 1'b1;
      a_in[k] = '0;
      b_in[k] = '0;
      n_acc[k] = 0;
      n_res[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("reset in_ready", k, {31'd0, in_ready[k]}, 1);
      check("reset out_valid", k, {31'd0, out_valid[k]}, 0);
      check("reset P", k, {16'd0, p_out[k]}, 0);
    end
    check_en = 1'b1;

    applyStimulus(0, 8'd15, 8'd15, c);
    checkOutput(0, 225, 4, c);
    @(posedge clk);
    #1;
    check("idle in_ready after transfer", 0, {31'd0, in_ready[0]}, 1);
    check("idle out_valid after transfer", 0, {31'd0, out_valid[0]}, 0);

    applyStimulus(2, 8'd255, 8'd255, c);
    checkOutput(2, 65025, 16, c);
    applyStimulus(2, 8'hA5, 8'h3C, c);
    checkOutput(2, 9900, 16, c);
    applyStimulus(1, 8'd63, 8'd63, c);
    checkOutput(1, 3969, 9, c);
    applyStimulus(1, 8'd0, 8'd45, c);
    checkOutput(1, 0, 9, c);

    // Backpressure: result must sit still while the sink stalls.
    @(posedge clk);
    #1;
    out_ready[0] = 1'b0;
    applyStimulus(0, 8'd13, 8'd11, c);
    checkOutput(0, 143, 4, c);
    repeat (4) begin
      @(negedge clk);
      check("stall out_valid", 0, {31'd0, out_valid[0]}, 1);
      check("stall P", 0, {16'd0, p_out[0]}, 143);
    end
    @(posedge clk);
    #1;
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    check("release out_valid", 0, {31'd0, out_valid[0]}, 0);
    check("release in_ready", 0, {31'd0, in_ready[0]}, 1);

    // Back-to-back: second pair taken on the edge the first result leaves.
    applyStimulus(0, 8'd6, 8'd5, c1);
    fork
      checkOutput(0, 30, 4, c1);
      applyStimulus(0, 8'd7, 8'd9, c2);
    join
    check("back-to-back accept spacing", 0, c2 - c1, 5);
    checkOutput(0, 63, 4, c2);
    @(posedge clk);
    #1;

    // Reset in the middle of a run discards the result.
    applyStimulus(0, 8'd15, 8'd15, c);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("mid-run reset out_valid", 0, {31'd0, out_valid[0]}, 0);
    check("mid-run reset P", 0, {16'd0, p_out[0]}, 0);
    check("mid-run reset in_ready", 0, {31'd0, in_ready[0]}, 1);
    applyStimulus(0, 8'd3, 8'd3, c);
    checkOutput(0, 9, 4, c);
    @(posedge clk);
    #1;

    for (int k = 0; k < 3; k++) begin
      n_acc[k] = 0;
      n_res[k] = 0;
    end
    sweep_on = 1'b1;
    fork
      sweep(0, 400);
      sweep(1, 300);
      sweep(2, 300);
    join
    sweep_on = 1'b0;
    @(posedge clk);
    #2;
    for (int k = 0; k < 3; k++) out_ready[k] = 1'b1;
    w = 0;
    while ((sb[0].size() + sb[1].size() + sb[2].size()) > 0 && w < 100) begin
      @(posedge clk);
      w++;
    end
    @(negedge clk);
    check("sweep accepts W4", 0, n_acc[0], 400);
    check("sweep accepts W6", 1, n_acc[1], 300);
    check("sweep accepts W8", 2, n_acc[2], 300);
    for (int k = 0; k < 3; k++) begin
      check("sweep drained", k, sb[k].size(), 0);
      check("results equal accepts", k, n_res[k], n_acc[k]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
